// File: rtl/ctrl_pkg.sv
// Shared opcode/func constants, ALUOp encodings, FSM states and the control
// bundle for the multi-cycle MIPS controller.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;

   localparam logic [5:0] FN_MUL = 6'b000010;
   localparam logic [5:0] FN_ROT = 6'b000110;
   localparam logic [5:0] FN_CL1 = 6'b100001;
   localparam logic [5:0] FN_CLZ = 6'b100000;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;
   localparam logic [3:0] ALU_OR  = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_ROT = 4'b1010;
   localparam logic [3:0] ALU_CL1 = 4'b1011;
   localparam logic [3:0] ALU_CLZ = 4'b1100;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MULWAIT,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MUL,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH
   } cls_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       shl_sel;
      logic       shr_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   function automatic ctrl_t mk_ctrl(input logic [3:0] alu_op, input logic alu_src,
                                     input logic reg_dst, input logic mem_to_reg,
                                     input logic shift);
      ctrl_t c;
      c.alu_op     = alu_op;
      c.alu_src    = alu_src;
      c.reg_dst    = reg_dst;
      c.mem_to_reg = mem_to_reg;
      c.shl_sel    = shift;
      c.shr_sel    = shift;
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Op/func classifier: control bundle, legal flag and class.
// SPECIAL2 encodings decode only when CTRL_SPECIAL2_EN is defined.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output ctrl_t      ctrl,
   output logic       legal,
   output cls_t       cls
);

   always_comb begin
      ctrl  = CTRL_NONE;
      legal = 1'b1;
      cls   = CLS_ALU;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADD:  ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_SUB:  ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_AND:  ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_OR:   ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b1, 1'b0, 1'b0);
               FN_SLT:  ctrl = mk_ctrl(ALU_SLT, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_SLL:  ctrl = mk_ctrl(ALU_SLL, 1'b0, 1'b1, 1'b0, 1'b1);
               FN_SRL:  ctrl = mk_ctrl(ALU_SRL, 1'b0, 1'b1, 1'b0, 1'b1);
               default: legal = 1'b0;
            endcase
         end
         OP_SPECIAL2: begin
`ifdef CTRL_SPECIAL2_EN
            case (func)
               FN_MUL: begin
                  ctrl = mk_ctrl(ALU_MUL, 1'b0, 1'b1, 1'b0, 1'b0);
                  cls  = CLS_MUL;
               end
               FN_ROT:  ctrl = mk_ctrl(ALU_ROT, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_CL1:  ctrl = mk_ctrl(ALU_CL1, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_CLZ:  ctrl = mk_ctrl(ALU_CLZ, 1'b0, 1'b1, 1'b0, 1'b0);
               default: legal = 1'b0;
            endcase
`else
            legal = 1'b0;
`endif
         end
         OP_ADDI: ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
         OP_LW: begin
            ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
            cls  = CLS_LOAD;
         end
         OP_SW: begin
            ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
            cls  = CLS_STORE;
         end
         OP_BEQ: begin
            ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
            cls  = CLS_BRANCH;
         end
         default: legal = 1'b0;
      endcase
      // an illegal word must not leak a partial bundle into the datapath
      if (!legal) begin
         ctrl = CTRL_NONE;
         cls  = CLS_ALU;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller FSM with registered control bundle.
// Optional macro CTRL_SPECIAL2_EN enables SPECIAL2 ops and the MUL wait counter.
//
// state     | meaning
// S_FETCH   | wait for InstrValid, latch Op/func, IRWrite/PCWrite
// S_DECODE  | classify latched word, register control bundle
// S_EXEC    | ALU cycle; BEQ drives PCSrc here
// S_MULWAIT | MUL down-counter running
// S_MEM     | MemRead/MemWrite held until MemReady
// S_WB      | RegWrite for one cycle
// S_TRAP    | illegal instruction, held until reset
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W    = 4,
   parameter int MUL_CYCLES = 4
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [5:0]         Op,
   input  logic [5:0]         func,
   input  logic               InstrValid,
   input  logic               MemReady,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrc,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               PCSrc,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               shl_sel,
   output logic               shr_sel,
   output logic               Busy,
   output logic               Illegal
);

   state_t     state;
   logic [5:0] op_q;
   logic [5:0] func_q;
   ctrl_t      ctrl_q;
   cls_t       cls_q;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       pc_src;

   ctrl_t      dec_ctrl;
   logic       dec_legal;
   cls_t       dec_cls;

`ifdef CTRL_SPECIAL2_EN
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
   logic [3:0] cnt;
`endif

   // decoding from the latched word keeps Op/func off every output path
   ctrl_decode u_decode (
      .op    (op_q),
      .func  (func_q),
      .ctrl  (dec_ctrl),
      .legal (dec_legal),
      .cls   (dec_cls)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= S_FETCH;
         op_q      <= '0;
         func_q    <= '0;
         ctrl_q    <= CTRL_NONE;
         cls_q     <= CLS_ALU;
         reg_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         pc_src    <= 1'b0;
`ifdef CTRL_SPECIAL2_EN
         cnt       <= '0;
`endif
      end else begin
         reg_write <= 1'b0;
         pc_src    <= 1'b0;
         case (state)
            S_FETCH: begin
               if (InstrValid) begin
                  op_q   <= Op;
                  func_q <= func;
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (dec_legal) begin
                  ctrl_q <= dec_ctrl;
                  cls_q  <= dec_cls;
                  pc_src <= (dec_cls == CLS_BRANCH);
                  state  <= S_EXEC;
               end else begin
                  state  <= S_TRAP;
               end
            end
            S_EXEC: begin
               case (cls_q)
                  CLS_LOAD: begin
                     mem_read <= 1'b1;
                     state    <= S_MEM;
                  end
                  CLS_STORE: begin
                     mem_write <= 1'b1;
                     state     <= S_MEM;
                  end
                  CLS_BRANCH: begin
                     ctrl_q <= CTRL_NONE;
                     state  <= S_FETCH;
                  end
`ifdef CTRL_SPECIAL2_EN
                  CLS_MUL: begin
                     cnt <= MUL_LOAD;
                     if (MUL_CYCLES > 1) begin
                        state <= S_MULWAIT;
                     end else begin
                        reg_write <= 1'b1;
                        state     <= S_WB;
                     end
                  end
`endif
                  default: begin
                     reg_write <= 1'b1;
                     state     <= S_WB;
                  end
               endcase
            end
`ifdef CTRL_SPECIAL2_EN
            S_MULWAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  reg_write <= 1'b1;
                  state     <= S_WB;
               end
            end
`endif
            S_MEM: begin
               if (MemReady) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (cls_q == CLS_LOAD) begin
                     reg_write <= 1'b1;
                     state     <= S_WB;
                  end else begin
                     ctrl_q <= CTRL_NONE;
                     state  <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               ctrl_q <= CTRL_NONE;
               state  <= S_FETCH;
            end
            S_TRAP:  state <= S_TRAP;
            default: state <= S_FETCH;
         endcase
      end
   end

   assign IRWrite  = (state == S_FETCH) & InstrValid;
   assign PCWrite  = (state == S_FETCH) & InstrValid;
   assign Busy     = (state != S_FETCH);
   assign Illegal  = (state == S_TRAP);
   assign RegWrite = reg_write;
   assign MemRead  = mem_read;
   assign MemWrite = mem_write;
   assign PCSrc    = pc_src;
   assign ALUOp    = ALUOP_W'(ctrl_q.alu_op);
   assign ALUSrc   = ctrl_q.alu_src;
   assign RegDst   = ctrl_q.reg_dst;
   assign MemtoReg = ctrl_q.mem_to_reg;
   assign shl_sel  = ctrl_q.shl_sel;
   assign shr_sel  = ctrl_q.shr_sel;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller plus trap and reset-in-MEM sequences.
module tb_multicycle_controller;

   localparam int ALUOP_W = 6;

   logic               Clk = 1'b0;
   logic               Rst_n;
   logic [5:0]         Op;
   logic [5:0]         func;
   logic               InstrValid;
   logic               MemReady;
   logic               IRWrite, PCWrite, RegDst, RegWrite, ALUSrc;
   logic               MemRead, MemWrite, MemtoReg, PCSrc;
   logic [ALUOP_W-1:0] ALUOp;
   logic               shl_sel, shr_sel, Busy, Illegal;

   int ncmp  = 0;
   int nfail = 0;
   int row   = -1;

   always #5 Clk = ~Clk;

   multicycle_controller #(.ALUOP_W(ALUOP_W), .MUL_CYCLES(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .func(func), .InstrValid(InstrValid),
      .MemReady(MemReady), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .PCSrc(PCSrc), .ALUOp(ALUOp), .shl_sel(shl_sel),
      .shr_sel(shr_sel), .Busy(Busy), .Illegal(Illegal)
   );

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int         wait_n;   // MemReady low cycles in MEM
      int         end_c;    // first cycle with Busy=0 (fetch cycle = 1)
      int         rw_c;     // RegWrite cycle, 0 = none
      int         mr;       // MemRead cycles
      int         mw;       // MemWrite cycles
      int         pc;       // PCSrc cycles
      logic [3:0] alu;
      logic       rd;
      logic       src;
      logic       m2r;
      logic       sh;
      logic       ill;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s (row %0d): got %0d, want %0d", name, row, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst_n = 1'b0;
      InstrValid = 1'b0;
      #1;
      check("reset_illegal", Illegal, 0);
      check("reset_busy", Busy, 0);
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic run(input vec_t v);
      int cyc, rw_n, rw_c, mr, mw, pc, pc_c, ir_busy, trap_c, mem_n, end_c;
      logic [ALUOP_W-1:0] alu_e, alu_end;
      logic rd_e, src_e, m2r_e, shl_e, shr_e, unstable, done;
      cyc = 1; rw_n = 0; rw_c = 0; mr = 0; mw = 0; pc = 0; pc_c = 0;
      ir_busy = 0; trap_c = 0; mem_n = 0; end_c = 0; unstable = 1'b0; done = 1'b0;
      alu_e = '0; alu_end = '0; rd_e = 0; src_e = 0; m2r_e = 0; shl_e = 0; shr_e = 0;
      @(negedge Clk);
      Op = v.op; func = v.fn; InstrValid = 1'b1; MemReady = 1'b1;
      #1;
      check("fetch_ir_pc_write", {30'd0, IRWrite, PCWrite}, 3);
      while (!done && cyc < 60) begin
         @(negedge Clk);
         InstrValid = 1'b0;
         Op = 6'($urandom);
         func = 6'($urandom);
         #1;
         cyc++;
         if (RegWrite) begin rw_n++; rw_c = cyc; end
         if (MemRead) mr++;
         if (MemWrite) mw++;
         if (PCSrc) begin pc++; pc_c = cyc; end
         if (cyc == 3) begin
            alu_e = ALUOp; rd_e = RegDst; src_e = ALUSrc; m2r_e = MemtoReg;
            shl_e = shl_sel; shr_e = shr_sel;
         end else if (cyc > 3 && Busy &&
                      {alu_e, rd_e, src_e, m2r_e, shl_e, shr_e} !=
                      {ALUOp, RegDst, ALUSrc, MemtoReg, shl_sel, shr_sel}) begin
            unstable = 1'b1;
         end
         MemReady = (MemRead | MemWrite) ? (mem_n == v.wait_n) : 1'b1;
         if (MemRead | MemWrite) mem_n++;
         if (Illegal) begin
            trap_c = cyc; done = 1'b1;
         end else if (!Busy) begin
            end_c = cyc; alu_end = ALUOp; done = 1'b1;
         end else begin
            InstrValid = 1'b1;
            #1;
            if (IRWrite | PCWrite) ir_busy++;
         end
      end
      MemReady = 1'b0;
      check("completed_in_budget", {31'd0, done}, 1);
      check("rw_count", rw_n, (v.rw_c != 0) ? 1 : 0);
      check("mem_write_cycles", mw, v.mw);
      check("ir_write_while_busy", ir_busy, 0);
      if (v.ill) begin
         check("trap_cycle", trap_c, 3);
      end else begin
         check("end_cycle", end_c, v.end_c);
         check("rw_cycle", rw_c, v.rw_c);
         check("mem_read_cycles", mr, v.mr);
         check("pcsrc_cycles", pc, v.pc);
         if (v.pc != 0) check("pcsrc_cycle", pc_c, 3);
         check("aluop", int'(alu_e), int'({2'b00, v.alu}));
         check("regdst", rd_e, v.rd);
         check("alusrc", src_e, v.src);
         check("memtoreg", m2r_e, v.m2r);
         check("shl_sel", shl_e, v.sh);
         check("shr_sel", shr_e, v.sh);
         check("bundle_stable", unstable, 0);
         check("aluop_in_fetch", int'(alu_end), 0);
      end
   endtask

   task automatic trap_sticky();
      int bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         InstrValid = ~InstrValid;
         MemReady = InstrValid;
         #1;
         if (!Illegal || IRWrite || PCWrite || RegWrite || MemRead || MemWrite || PCSrc) bad++;
      end
      InstrValid = 1'b0;
      check("trap_sticky", bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      vec_t add_v;
      Rst_n = 1'b0; InstrValid = 1'b0; Op = '0; func = '0; MemReady = 1'b0;

      //                op         fn         wt end rw mr mw pc alu    rd    src   m2r   sh    ill
      vecs.push_back('{6'b000000, 6'b100000, 0, 5, 4, 0, 0, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b000000, 6'b100010, 0, 5, 4, 0, 0, 0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b000000, 6'b100100, 0, 5, 4, 0, 0, 0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b000000, 6'b100101, 0, 5, 4, 0, 0, 0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b000000, 6'b101010, 0, 5, 4, 0, 0, 0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b000000, 6'b000000, 0, 5, 4, 0, 0, 0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{6'b000000, 6'b000010, 0, 5, 4, 0, 0, 0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{6'b001000, 6'b000000, 0, 5, 4, 0, 0, 0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b100011, 6'b000000, 3, 9, 8, 4, 0, 0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{6'b100011, 6'b000000, 0, 6, 5, 1, 0, 0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{6'b101011, 6'b000000, 2, 7, 0, 0, 3, 0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b101011, 6'b000000, 0, 5, 0, 0, 1, 0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b000100, 6'b000000, 0, 4, 0, 0, 0, 1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef CTRL_SPECIAL2_EN
      vecs.push_back('{6'b011100, 6'b000010, 0, 8, 7, 0, 0, 0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b011100, 6'b000110, 0, 5, 4, 0, 0, 0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b011100, 6'b100001, 0, 5, 4, 0, 0, 0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{6'b011100, 6'b100000, 0, 5, 4, 0, 0, 0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`else
      vecs.push_back('{6'b011100, 6'b000010, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{6'b011100, 6'b100000, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`endif
      vecs.push_back('{6'b111111, 6'b000000, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{6'b000000, 6'b111111, 0, 0, 0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      add_v = vecs[0];

      repeat (3) @(negedge Clk);
      #1;
      check("reset_outputs",
            {19'd0, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
             MemtoReg, PCSrc, shl_sel, shr_sel, Busy, Illegal}, 0);
      check("reset_aluop", int'(ALUOp), 0);
      @(negedge Clk);
      Rst_n = 1'b1;

      bad = 0;
      repeat (4) begin
         @(negedge Clk);
         MemReady = 1'b1;
         #1;
         if (Busy || IRWrite || RegWrite || MemRead || MemWrite) bad++;
      end
      check("idle_fetch", bad, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         row = i;
         run(vecs[i]);
         if (vecs[i].ill) begin
            trap_sticky();
            do_reset();
         end
      end

      // SW abandoned by reset while waiting in MEM
      row = 100;
      @(negedge Clk);
      Op = 6'b101011; func = 6'b000000; InstrValid = 1'b1; MemReady = 1'b0;
      @(negedge Clk);
      InstrValid = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      check("sw_mem_write_high", MemWrite, 1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("sw_async_drop", MemWrite, 0);
      check("sw_async_busy", Busy, 0);
      MemReady = 1'b1;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge Clk);
         #1;
         if (MemWrite || RegWrite || Busy) bad++;
      end
      check("sw_never_reasserts", bad, 0);
      row = 101;
      run(add_v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle MIPS instruction controller: decodes Op/func once per instruction and sequences the datapath through fetch, decode, execute, memory and write-back states. It adds a configurable multi-cycle multiply wait, a memory-ready handshake, illegal-instruction trapping and a parametrised ALUOp width. It sits between the instruction register and the datapath muxes, register file and data memory of the lab processor.

## Interface
- ALUOP_W, 4: ALUOp width, minimum 4; bits above [3:0] driven 0.
- MUL_CYCLES, 4: execute cycles for MUL, range 1..15.

- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Op  in  6  opcode from instruction memory
- func  in  6  function field from instruction memory
- InstrValid  in  1  instruction word present on Op/func
- MemReady  in  1  data memory completes the access this cycle
- IRWrite, PCWrite  out  1  load IR / PC+4
- RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, PCSrc  out  1  datapath controls
- ALUOp  out  ALUOP_W  ALU operation
- shl_sel, shr_sel  out  1  shifter path select
- Busy  out  1  instruction in flight (state != FETCH)
- Illegal  out  1  sticky trap flag

## Operation
- States: FETCH, DECODE, EXEC, MULWAIT, MEM, WB, TRAP.
- FETCH: IRWrite = PCWrite = InstrValid; Op/func latched on that edge; go to DECODE. Otherwise remain in FETCH.
- DECODE: classify the latched Op/func. Register the control bundle, which is held until the next FETCH. Illegal encoding -> TRAP.
- R-type (Op 000000): ADD 100000->0000, SUB 100010->0001, AND 100100->0011, OR 100101->0100, SLT 101010->0101, SLL 000000->1000, SRL 000010->1001. SLL and SRL also set shl_sel = shr_sel = 1.
- SPECIAL2 (Op 011100): MUL 000010->0010, ROT 000110->1010, CL1 100001->1011, CLZ 100000->1100.
- I-type: ADDI 001000 (ALUSrc=1, ALUOp 0000); LW 100011 and SW 101011 (ALUSrc=1, ALUOp 0000); BEQ 000100 (ALUOp 0001).
- EXEC: ALU/R-type/ADDI go to WB; MUL goes to MULWAIT; LW/SW go to MEM. BEQ asserts PCSrc = 1 for one cycle, then goes to FETCH.
- MULWAIT: a down-counter loaded with MUL_CYCLES-1 in EXEC; go to WB when the counter reaches 0. For MUL_CYCLES = 1, skip MULWAIT entirely.
- MEM: MemRead (LW) or MemWrite (SW) is held until MemReady = 1. LW then goes to WB; SW goes to FETCH. There is no timeout.
- WB: RegWrite = 1 for exactly one cycle. RegDst = 1 for R-type/SPECIAL2 and 0 for ADDI/LW. MemtoReg = 1 only for LW. Then go to FETCH.
- TRAP: all strobes 0; Illegal = 1; remain in TRAP until reset.

## Timing
- Reset: state FETCH, counter 0. All outputs are 0, including ALUOp, Busy and Illegal.
- Strobes (IRWrite, PCWrite, RegWrite, MemRead, MemWrite, PCSrc) are Moore outputs of the state plus the registered bundle. There is no combinational path from Op/func to any output.
- Exception: IRWrite and PCWrite follow InstrValid combinationally while in FETCH.
- Latency, counted from the FETCH handshake edge:
  - R-type/ADDI: 4 cycles
  - BEQ: 3 cycles
  - SW: 4 + memory-wait cycles
  - LW: 5 + memory-wait cycles
  - MUL: 4 + MUL_CYCLES-1 cycles
- MemReady outside MEM is ignored. If MemReady is high on the first MEM cycle, MEM lasts 1 cycle.
- Reset asserted mid-instruction: the instruction is abandoned immediately, and RegWrite/MemWrite are never asserted for it.
- The bundle (ALUOp, ALUSrc, RegDst, MemtoReg, shl_sel, shr_sel) is stable from DECODE+1 through the last state of the instruction. It reads 0 in FETCH.

## Configuration
- CTRL_SPECIAL2_EN defined: MUL, ROT, CL1 and CLZ decode as above, and MULWAIT and its counter exist.
- Not defined: every Op 011100 encoding is illegal -> TRAP, and MULWAIT and the counter are removed.

## Structure
- Package ctrl_pkg:
  - opcode and func constants
  - ALUOp encodings
  - state enum
  - packed control-bundle struct
- Sub-module ctrl_decode: purely combinational mapping from Op/func to the control bundle plus a legal flag and class (ALU, MUL, LOAD, STORE, BRANCH).
- The FSM, counter and registered bundle live in multicycle_controller.

## Test plan
- Reset, then ADD (Op 000000, func 100000) with InstrValid=1 -> RegWrite=1 on cycle 4 with RegDst=1, ALUOp=0000; Busy drops on cycle 5.
- LW (100011) with MemReady held low 3 cycles -> MemRead high for 4 cycles, then WB with MemtoReg=1, RegDst=0.
- MUL (011100/000010), MUL_CYCLES=4 -> RegWrite on cycle 7, ALUOp=0010 stable throughout. With CTRL_SPECIAL2_EN undefined -> Illegal=1 after DECODE.
- BEQ (000100) -> PCSrc=1 only in EXEC, no RegWrite; next FETCH on cycle 4.
- Op 111111 -> TRAP, Illegal stays 1 with InstrValid toggling; Rst_n low -> Illegal=0, state FETCH.
- SW with Rst_n asserted during MEM -> MemWrite drops asynchronously and never reasserts; next instruction fetches normally.
